// File: rtl/ahb_lite_eic_regs.sv
// AHB-Lite register file feeding the eic core: mask, sense modes, forced request strobes.
// Optional AHB_EIC_ERROR_RESP_EN adds a two-cycle ERROR response for illegal accesses.
module ahb_lite_eic_regs #(
    parameter int EIC_DIRECT_CHANNELS = 31,
    parameter int EIC_SENSE_CHANNELS  = 32,
    parameter int EIC_TOTAL_CHANNELS  = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
    input  logic                            CLK,
    input  logic                            RESETn,
    input  logic                            HSEL,
    input  logic                            HWRITE,
    input  logic [1:0]                      HTRANS,
    input  logic [31:0]                     HADDR,
    input  logic [2:0]                      HSIZE,
    input  logic [31:0]                     HWDATA,
    input  logic                            HREADY,
    output logic [31:0]                     HRDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    input  logic [EIC_TOTAL_CHANNELS-1:0]   request,
    input  logic [7:0]                      EIC_Interrupt,
    output logic [EIC_TOTAL_CHANNELS-1:0]   mask,
    output logic [2*EIC_SENSE_CHANNELS-1:0] senceMask,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestWR,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestIn
);

    localparam int          SW       = 2 * EIC_SENSE_CHANNELS;
    localparam logic [63:0] CH_VALID = (64'd1 << EIC_TOTAL_CHANNELS) - 64'd1;
    localparam logic [63:0] SN_VALID = (64'd1 << SW) - 64'd1;

    localparam logic [3:0] A_CTRL    = 4'd0,  A_MASK_L  = 4'd1,  A_MASK_H  = 4'd2;
    localparam logic [3:0] A_IFR_L   = 4'd3,  A_IFR_H   = 4'd4,  A_IFS_L   = 4'd5;
    localparam logic [3:0] A_IFS_H   = 4'd6,  A_IFC_L   = 4'd7,  A_IFC_H   = 4'd8;
    localparam logic [3:0] A_SENSE_L = 4'd9,  A_SENSE_H = 4'd10, A_STATUS  = 4'd11;

    logic        r_valid, r_wr, r_word;
    logic [3:0]  r_addr;
    logic        r_ctrl;
    logic [63:0] r_mask, r_sense;
    logic [EIC_TOTAL_CHANNELS-1:0] r_req_wr, r_req_in;

    logic        w_accept, w_dp, w_we;
    logic [63:0] w_wdata_sh, w_half_keep, w_req64;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_accept = HSEL & HTRANS[1] & HREADY;
    assign w_we     = w_dp & r_wr & r_word;
    assign w_req64  = 64'(request);
    assign w_unused = ^{HTRANS[0], HADDR[31:6], HADDR[1:0]};

    // Every *_L register sits at an odd word index, every *_H at an even one.
    assign w_wdata_sh  = r_addr[0] ? {32'b0, HWDATA} : {HWDATA, 32'b0};
    assign w_half_keep = r_addr[0] ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
            r_word  <= 1'b0;
            r_addr  <= 4'd0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_wr    <= HWRITE;
            r_word  <= (HSIZE == 3'b010);
            r_addr  <= HADDR[5:2];
        end else if (HREADY) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ctrl   <= 1'b0;
            r_mask   <= 64'd0;
            r_sense  <= SN_VALID;
            r_req_wr <= '0;
            r_req_in <= '0;
        end else begin
            r_req_wr <= '0;
            r_req_in <= '0;
            if (w_we) begin
                case (r_addr)
                    A_CTRL:             r_ctrl  <= HWDATA[0];
                    A_MASK_L, A_MASK_H: r_mask  <= ((r_mask & w_half_keep) | w_wdata_sh) & CH_VALID;
                    A_IFS_L, A_IFS_H: begin
                        r_req_wr <= EIC_TOTAL_CHANNELS'(w_wdata_sh);
                        r_req_in <= EIC_TOTAL_CHANNELS'(w_wdata_sh);
                    end
                    A_IFC_L, A_IFC_H:   r_req_wr <= EIC_TOTAL_CHANNELS'(w_wdata_sh);
                    A_SENSE_L, A_SENSE_H:
                        r_sense <= ((r_sense & w_half_keep) | w_wdata_sh) & SN_VALID;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_dp && !r_wr) begin
            case (r_addr)
                A_CTRL:    w_rdata = {31'd0, r_ctrl};
                A_MASK_L:  w_rdata = r_mask[31:0];
                A_MASK_H:  w_rdata = r_mask[63:32];
                A_IFR_L:   w_rdata = w_req64[31:0];
                A_IFR_H:   w_rdata = w_req64[63:32];
                A_SENSE_L: w_rdata = r_sense[31:0];
                A_SENSE_H: w_rdata = r_sense[63:32];
                A_STATUS:  w_rdata = {24'd0, EIC_Interrupt};
                default:   w_rdata = 32'd0;
            endcase
        end
    end

    assign HRDATA    = w_rdata;
    assign mask      = EIC_TOTAL_CHANNELS'(r_mask) & {EIC_TOTAL_CHANNELS{r_ctrl}};
    assign senceMask = SW'(r_sense);
    assign requestWR = r_req_wr;
    assign requestIn = r_req_in;

`ifdef AHB_EIC_ERROR_RESP_EN
    // state    | meaning
    // ST_OKAY  | normal data phases; an illegal access drives ERROR cycle 1 here
    // ST_ERR2  | second ERROR cycle, HREADYOUT back high, next transfer may start
    typedef enum logic {ST_OKAY, ST_ERR2} state_t;
    state_t r_state, w_state_nxt;
    logic   w_bad, w_hreadyout, w_hresp;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) r_state <= ST_OKAY;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        case (r_addr)
            A_IFR_L, A_IFR_H, A_STATUS: w_bad = r_wr;
            A_CTRL, A_MASK_L, A_MASK_H, A_IFS_L, A_IFS_H,
            A_IFC_L, A_IFC_H, A_SENSE_L, A_SENSE_H: w_bad = 1'b0;
            default: w_bad = 1'b1;
        endcase
        case (r_state)
            ST_OKAY: if (r_valid && w_bad) begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                w_hresp     = 1'b1;
                w_state_nxt = ST_OKAY;
            end
            default: w_state_nxt = ST_OKAY;
        endcase
    end

    // The errored transfer's valid bit lingers through cycle 2; keep it out of the data path.
    assign w_dp      = r_valid & (r_state == ST_OKAY);
    assign HREADYOUT = w_hreadyout;
    assign HRESP     = w_hresp;
`else
    assign w_dp      = r_valid;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

endmodule
